tpu_tile_sequencer: RTL and testbench

Multi-tile top-level sequencer for the systolic TPU datapath. Accepts a start command with a tile count, then runs that many read -> compute -> write passes against the read, compute and write engines. Each pass is gated on input-FIFO availability and output-FIFO space, and every engine phase is guarded by a watchdog. Sits between the host/command interface and the engine control inputs.

---
 rtl/tpu_tile_sequencer.sv | 162 ++++++++++++++++
 tb/tb_tpu_tile_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_tile_sequencer.sv
// Multi-tile sequencer: runs num_tiles read -> compute -> write passes against the
// engines, gated on FIFO readiness, with a per-phase watchdog and abort.
module tpu_tile_sequencer #(
    parameter int TILE_W    = 8,
    parameter int TIMEOUT_W = 16,
    parameter int TIMEOUT   = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tpu_start,
    input  logic [TILE_W-1:0] num_tiles,
    input  logic              abort,
    input  logic              rempty,
    input  logic              wfull,
    input  logic              read_done,
    input  logic              compute_done,
    input  logic              write_done,
    output logic              read_start,
    output logic              compute_start,
    output logic              write_start,
    output logic              busy,
    output logic [TILE_W-1:0] tile_idx,
    output logic              tpu_done,
    output logic              timeout_err,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        READ    = 3'd2,
        COMP    = 3'd3,
        WR_WAIT = 3'd4,
        WRITE   = 3'd5,
        ERR     = 3'd6
    } state_e;

    localparam bit                   WD_EN   = (TIMEOUT != 0);
    localparam logic [TIMEOUT_W-1:0] WD_LAST = WD_EN ? TIMEOUT_W'(TIMEOUT - 1) : '0;

    state_e              state_q, state_d;
    logic [TILE_W-1:0]   num_q, num_d;
    logic [TILE_W-1:0]   tile_q, tile_d;
    logic [TIMEOUT_W-1:0] wd_q, wd_d;
    logic                err_q, err_d;
    logic                done_q, done_d;
    logic                rs_q, rs_d;
    logic                cs_q, cs_d;
    logic                ws_q, ws_d;
    logic                wd_expire;

    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        tile_d    = tile_q;
        err_d     = err_q;
        done_d    = 1'b0;
        wd_expire = WD_EN && (wd_q == WD_LAST);

        case (state_q)
            IDLE: begin
                if (tpu_start) begin
                    if (num_tiles != '0) begin
                        num_d   = num_tiles;
                        tile_d  = '0;
                        state_d = RD_WAIT;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RD_WAIT: if (!rempty) state_d = READ;
            READ: begin
                if (read_done) begin
                    state_d = COMP;
                end else if (wd_expire) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end
            end
            COMP: begin
                if (compute_done) begin
                    state_d = WR_WAIT;
                end else if (wd_expire) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end
            end
            WR_WAIT: if (!wfull) state_d = WRITE;
            WRITE: begin
                if (write_done) begin
                    if (tile_q == num_q - 1'b1) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        tile_d  = tile_q + 1'b1;
                        state_d = RD_WAIT;
                    end
                end else if (wd_expire) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end
            end
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase

        // Abort overrides every transition above, including the tpu_done pulse.
        if (abort) begin
            state_d = IDLE;
            err_d   = 1'b0;
            tile_d  = '0;
            done_d  = 1'b0;
        end

        if (state_d != state_q) begin
            wd_d = '0;
        end else if (WD_EN && (state_q == READ || state_q == COMP || state_q == WRITE)) begin
            wd_d = wd_q + 1'b1;
        end else begin
            wd_d = wd_q;
        end

        rs_d = (state_d == READ)  && (state_q != READ);
        cs_d = (state_d == COMP)  && (state_q != COMP);
        ws_d = (state_d == WRITE) && (state_q != WRITE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            num_q   <= '0;
            tile_q  <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            rs_q    <= 1'b0;
            cs_q    <= 1'b0;
            ws_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            tile_q  <= tile_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
            done_q  <= done_d;
            rs_q    <= rs_d;
            cs_q    <= cs_d;
            ws_q    <= ws_d;
        end
    end

    assign read_start    = rs_q;
    assign compute_start = cs_q;
    assign write_start   = ws_q;
    assign busy          = (state_q != IDLE);
    assign tile_idx      = tile_q;
    assign tpu_done      = done_q;
    assign timeout_err   = err_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// Bench for tpu_tile_sequencer: job timelines derived from per-tile durations,
// plus directed sequences for zero tiles, watchdog, abort and async reset.
module tb_tpu_tile_sequencer;

    localparam int MAXC = 2048;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tpu_start = 1'b0;
    logic [7:0] num_tiles = '0;
    logic       abort = 1'b0;
    logic       rempty = 1'b0;
    logic       wfull = 1'b0;
    logic       read_done = 1'b0;
    logic       compute_done = 1'b0;
    logic       write_done = 1'b0;
    logic       read_start, compute_start, write_start, busy, tpu_done, timeout_err;
    logic [7:0] tile_idx;
    logic [2:0] state_dbg;

    tpu_tile_sequencer #(
        .TILE_W   (8),
        .TIMEOUT_W(16),
        .TIMEOUT  (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tpu_start    (tpu_start),
        .num_tiles    (num_tiles),
        .abort        (abort),
        .rempty       (rempty),
        .wfull        (wfull),
        .read_done    (read_done),
        .compute_done (compute_done),
        .write_done   (write_done),
        .read_start   (read_start),
        .compute_start(compute_start),
        .write_start  (write_start),
        .busy         (busy),
        .tile_idx     (tile_idx),
        .tpu_done     (tpu_done),
        .timeout_err  (timeout_err),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Per-cycle stimulus and expectations for one job.
    bit         i_start[MAXC], i_re[MAXC], i_wf[MAXC], i_rd[MAXC], i_cd[MAXC], i_wd[MAXC];
    logic [7:0] i_num[MAXC];
    int         e_st[MAXC];
    bit         e_rs[MAXC], e_cs[MAXC], e_ws[MAXC], e_done[MAXC];
    logic [7:0] e_tile[MAXC];
    int         len;

    // Per-tile durations: extra wait cycles and done latency after each start.
    int wr_a[256], lr_a[256], lc_a[256], ww_a[256], lw_a[256];
    int cnt_busy, cnt_rs, cnt_cs, cnt_ws, cnt_done;

    typedef struct {
        int n, wr, lr, lc, ww, lw;
        int exp_busy;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] pk(input bit b, rs, cs, ws, dn, er, input int st);
        return {23'd0, b, rs, cs, ws, dn, er, 3'(st)};
    endfunction

    function automatic logic [31:0] outs();
        return {23'd0, busy, read_start, compute_start, write_start, tpu_done, timeout_err, state_dbg};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        tpu_start = 1'b0; num_tiles = '0; abort = 1'b0; rempty = 1'b0; wfull = 1'b0;
        read_done = 1'b0; compute_done = 1'b0; write_done = 1'b0;
    endtask

    task automatic uniform(input int n, wr, lr, lc, ww, lw);
        for (int k = 0; k < n; k++) begin
            wr_a[k] = wr; lr_a[k] = lr; lc_a[k] = lc; ww_a[k] = ww; lw_a[k] = lw;
        end
    endtask

    // Lay out the job on a cycle axis: cycle 0 carries tpu_start, each tile is
    // RD_WAIT(wr+1) READ(lr+1) COMP(lc+1) WR_WAIT(ww+1) WRITE(lw+1), then a done cycle.
    task automatic build_job(input int n, input bit noisy);
        int b, r, c, q, w, e;
        for (int t = 0; t < MAXC; t++) begin
            i_start[t] = 1'b0;
            i_num[t]   = noisy ? 8'($urandom) : 8'd0;
            i_re[t]    = noisy ? 1'($urandom) : 1'b0;
            i_wf[t]    = noisy ? 1'($urandom) : 1'b0;
            i_rd[t]    = noisy ? 1'($urandom) : 1'b0;
            i_cd[t]    = noisy ? 1'($urandom) : 1'b0;
            i_wd[t]    = noisy ? 1'($urandom) : 1'b0;
            e_st[t] = 0; e_rs[t] = 0; e_cs[t] = 0; e_ws[t] = 0; e_done[t] = 0;
            e_tile[t] = '0;
        end
        i_start[0] = 1'b1;
        i_num[0]   = 8'(n);
        b = 1;
        for (int k = 0; k < n; k++) begin
            r = b + wr_a[k] + 1;
            c = r + lr_a[k] + 1;
            q = c + lc_a[k] + 1;
            w = q + ww_a[k] + 1;
            e = w + lw_a[k];
            for (int t = b; t < r; t++) begin e_st[t] = 1; i_re[t] = (t < r - 1); end
            for (int t = r; t < c; t++) begin e_st[t] = 2; i_rd[t] = (t == c - 1); end
            for (int t = c; t < q; t++) begin e_st[t] = 3; i_cd[t] = (t == q - 1); end
            for (int t = q; t < w; t++) begin e_st[t] = 4; i_wf[t] = (t < w - 1); end
            for (int t = w; t <= e; t++) begin e_st[t] = 5; i_wd[t] = (t == e); end
            for (int t = b; t <= e; t++) begin
                e_tile[t] = 8'(k);
                if (noisy) i_start[t] = 1'($urandom);
            end
            e_rs[r] = 1; e_cs[c] = 1; e_ws[w] = 1;
            b = e + 1;
        end
        e_done[b] = 1;
        len = b + 1;
    endtask

    task automatic run_job(input string nm, input int n, input bit noisy);
        build_job(n, noisy);
        cnt_busy = 0; cnt_rs = 0; cnt_cs = 0; cnt_ws = 0; cnt_done = 0;
        for (int t = 0; t < len; t++) begin
            chk($sformatf("%s cyc%0d outs", nm, t), outs(),
                pk(e_st[t] != 0, e_rs[t], e_cs[t], e_ws[t], e_done[t], 1'b0, e_st[t]));
            if (e_st[t] != 0)
                chk($sformatf("%s cyc%0d tile_idx", nm, t), 32'(tile_idx), 32'(e_tile[t]));
            cnt_busy += int'(busy); cnt_rs += int'(read_start); cnt_cs += int'(compute_start);
            cnt_ws += int'(write_start); cnt_done += int'(tpu_done);
            tpu_start = i_start[t]; num_tiles = i_num[t]; abort = 1'b0;
            rempty = i_re[t]; wfull = i_wf[t];
            read_done = i_rd[t]; compute_done = i_cd[t]; write_done = i_wd[t];
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        tbl[0] = '{n: 1, wr: 0, lr: 2, lc: 2, ww: 0, lw: 2, exp_busy: 11};
        tbl[1] = '{n: 3, wr: 0, lr: 0, lc: 0, ww: 0, lw: 0, exp_busy: 15};
        tbl[2] = '{n: 2, wr: 1, lr: 1, lc: 3, ww: 2, lw: 0, exp_busy: 24};
        tbl[3] = '{n: 4, wr: 2, lr: 4, lc: 4, ww: 1, lw: 4, exp_busy: 80};
        tbl[4] = '{n: 1, wr: 3, lr: 0, lc: 1, ww: 3, lw: 2, exp_busy: 14};

        idle_inputs();
        #3;
        chk("reset outs", outs(), pk(0, 0, 0, 0, 0, 0, 0));
        chk("reset tile_idx", 32'(tile_idx), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            uniform(tbl[i].n, tbl[i].wr, tbl[i].lr, tbl[i].lc, tbl[i].ww, tbl[i].lw);
            run_job($sformatf("tbl%0d", i), tbl[i].n, 1'b0);
            chk($sformatf("tbl%0d busy cycles", i), 32'(cnt_busy), 32'(tbl[i].exp_busy));
            chk($sformatf("tbl%0d read_start count", i), 32'(cnt_rs), 32'(tbl[i].n));
            chk($sformatf("tbl%0d write_start count", i), 32'(cnt_ws), 32'(tbl[i].n));
            chk($sformatf("tbl%0d tpu_done count", i), 32'(cnt_done), 32'd1);
        end

        // Three tiles: rempty held 4 cycles before tile 1, wfull 3 cycles before tile 2's write.
        uniform(3, 0, 1, 1, 0, 1);
        wr_a[1] = 4; ww_a[2] = 3;
        run_job("waits", 3, 1'b0);
        chk("waits compute_start count", 32'(cnt_cs), 32'd3);

        // Done strobe arriving exactly as the watchdog expires must win.
        uniform(1, 0, 4, 4, 0, 4);
        run_job("expiry", 1, 1'b0);

        for (int j = 0; j < 20; j++) begin
            int n;
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                wr_a[k] = $urandom_range(0, 3); lr_a[k] = $urandom_range(0, 4);
                lc_a[k] = $urandom_range(0, 4); ww_a[k] = $urandom_range(0, 3);
                lw_a[k] = $urandom_range(0, 4);
            end
            run_job($sformatf("rnd%0d", j), n, 1'b1);
            chk($sformatf("rnd%0d tpu_done count", j), 32'(cnt_done), 32'd1);
        end

        uniform(255, 0, 0, 0, 0, 0);
        run_job("max", 255, 1'b0);
        chk("max busy cycles", 32'(cnt_busy), 32'd1275);

        // num_tiles = 0
        idle_inputs();
        tpu_start = 1'b1;
        tick();
        tpu_start = 1'b0;
        chk("zero tiles done", outs(), pk(0, 0, 0, 0, 1, 0, 0));
        tick();
        chk("zero tiles after", outs(), pk(0, 0, 0, 0, 0, 0, 0));

        // Watchdog on compute, then abort out of ERR.
        tpu_start = 1'b1; num_tiles = 8'd1;
        tick();
        tpu_start = 1'b0;
        chk("wd rd_wait", outs(), pk(1, 0, 0, 0, 0, 0, 1));
        tick();
        chk("wd read", outs(), pk(1, 1, 0, 0, 0, 0, 2));
        read_done = 1'b1;
        tick();
        read_done = 1'b0;
        chk("wd comp start", outs(), pk(1, 0, 1, 0, 0, 0, 3));
        for (int i = 1; i < 5; i++) begin
            tick();
            chk($sformatf("wd comp +%0d", i), outs(), pk(1, 0, 0, 0, 0, 0, 3));
        end
        tick();
        chk("wd err entry", outs(), pk(1, 0, 0, 0, 0, 1, 6));
        for (int i = 0; i < 4; i++) begin
            tpu_start = 1'b1; num_tiles = 8'($urandom);
            rempty = 1'($urandom); wfull = 1'($urandom);
            read_done = 1'b1; compute_done = 1'b1; write_done = 1'b1;
            tick();
            chk($sformatf("wd err sticky %0d", i), outs(), pk(1, 0, 0, 0, 0, 1, 6));
        end
        idle_inputs();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("wd abort outs", outs(), pk(0, 0, 0, 0, 0, 0, 0));
        tick();

        // Abort mid-job with tpu_start also high: abort wins, tile_idx clears.
        read_done = 1'b1; compute_done = 1'b1; write_done = 1'b1;
        tpu_start = 1'b1; num_tiles = 8'd3;
        tick();
        tpu_start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("abort pre outs", outs(), pk(1, 1, 0, 0, 0, 0, 2));
        chk("abort pre tile", 32'(tile_idx), 32'd1);
        abort = 1'b1; tpu_start = 1'b1; num_tiles = 8'd5;
        tick();
        abort = 1'b0; tpu_start = 1'b0;
        chk("abort outs", outs(), pk(0, 0, 0, 0, 0, 0, 0));
        chk("abort tile", 32'(tile_idx), 32'd0);
        tick();
        chk("abort idle", outs(), pk(0, 0, 0, 0, 0, 0, 0));

        // Async reset during tile 2's WRITE.
        tpu_start = 1'b1; num_tiles = 8'd3;
        tick();
        tpu_start = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk("rst pre outs", outs(), pk(1, 0, 0, 1, 0, 0, 5));
        chk("rst pre tile", 32'(tile_idx), 32'd2);
        #2 rst = 1'b0;
        #1;
        chk("rst async outs", outs(), pk(0, 0, 0, 0, 0, 0, 0));
        chk("rst async tile", 32'(tile_idx), 32'd0);
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();
        uniform(1, 0, 1, 1, 0, 1);
        run_job("post_rst", 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
